// File: rtl/dcache_types_pkg.sv
// Shared types, geometry constants and address-field helpers for the L1 data cache.
package dcache_types;

  localparam int unsigned S_OFFSET = 5;
  localparam int unsigned S_INDEX  = 3;
  localparam int unsigned S_TAG    = 32 - S_OFFSET - S_INDEX;
  localparam int unsigned S_LINE   = 8 << S_OFFSET;
  localparam int unsigned NUM_SETS = 2 ** S_INDEX;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} dcache_state_t;

  function automatic logic [S_TAG-1:0] addr_tag(input logic [31:0] addr);
    return addr[31:S_OFFSET+S_INDEX];
  endfunction

  function automatic logic [S_INDEX-1:0] addr_index(input logic [31:0] addr);
    return addr[S_OFFSET+S_INDEX-1:S_OFFSET];
  endfunction

  function automatic logic [S_OFFSET-3:0] addr_word(input logic [31:0] addr);
    return addr[S_OFFSET-1:2];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Flop-based array: combinational read, synchronous write with per-lane write mask.
module dcache_array #(
  parameter int unsigned Width    = 32,
  parameter int unsigned Depth    = 8,
  parameter int unsigned MaskW    = 1,
  parameter bit          HasReset = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic                     we_i,
  input  logic [MaskW-1:0]         wmask_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o
);

  localparam int unsigned Lane = Width / MaskW;

  logic [Width-1:0] mem_q [Depth];

  assign rdata_o = mem_q[addr_i];

  // Arrays without HasReset simply hold their contents while rst is high.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if (HasReset) begin
        for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      end
    end else if (we_i) begin
      for (int m = 0; m < int'(MaskW); m++) begin
        if (wmask_i[m]) mem_q[addr_i][m*Lane +: Lane] <= wdata_i[m*Lane +: Lane];
      end
    end
  end

endmodule

// File: rtl/l1_data_cache.sv
// Direct-mapped write-back, write-allocate L1 data cache with zero-wait hits and
// a WRITEBACK/ALLOCATE miss sequence against a line-wide memory port.
module l1_data_cache
  import dcache_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              data_read,
  input  logic              data_write,
  input  logic [3:0]        data_mbe,
  input  logic [31:0]       data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_resp,
  output logic [31:0]       data_rdata,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [S_LINE-1:0] pmem_wdata,
  input  logic [S_LINE-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  dcache_state_t state_q;
  logic [31:0]   miss_addr_q;
  logic          pmem_read_q, pmem_write_q;
  logic [31:0]   pmem_address_q;

  logic [S_INDEX-1:0]  idx;
  logic [S_OFFSET-3:0] word;
  logic [S_LINE-1:0]   line_rd;
  logic [S_TAG-1:0]    tag_rd;
  logic                valid_rd, dirty_rd;
  logic                req, hit, store_hit, fill, wb_done;

  // Once a miss is in flight, the latched address drives the arrays so a
  // wobbling request cannot redirect the writeback or fill.
  assign idx       = (state_q == IDLE) ? addr_index(data_addr) : addr_index(miss_addr_q);
  assign word      = addr_word(data_addr);
  assign req       = data_read | data_write;
  assign hit       = (state_q == IDLE) && req && valid_rd && (tag_rd == addr_tag(data_addr));
  assign store_hit = hit && data_write;
  assign fill      = (state_q == ALLOCATE) && pmem_resp;
  assign wb_done   = (state_q == WRITEBACK) && pmem_resp;

  assign data_resp    = hit;
  assign data_rdata   = hit ? line_rd[{word, 5'b0} +: 32] : '0;
  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = line_rd;

  dcache_array #(.Width(S_LINE), .Depth(NUM_SETS), .MaskW(32), .HasReset(1'b0)) u_data (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (idx),
    .we_i    (store_hit | fill),
    .wmask_i (fill ? '1 : (32'(data_mbe) << {word, 2'b00})),
    .wdata_i (fill ? pmem_rdata : {8{data_wdata}}),
    .rdata_o (line_rd)
  );

  dcache_array #(.Width(S_TAG), .Depth(NUM_SETS), .MaskW(1), .HasReset(1'b0)) u_tag (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (idx),
    .we_i    (fill),
    .wmask_i (1'b1),
    .wdata_i (addr_tag(miss_addr_q)),
    .rdata_o (tag_rd)
  );

  dcache_array #(.Width(1), .Depth(NUM_SETS), .MaskW(1), .HasReset(1'b1)) u_valid (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (idx),
    .we_i    (fill),
    .wmask_i (1'b1),
    .wdata_i (1'b1),
    .rdata_o (valid_rd)
  );

  dcache_array #(.Width(1), .Depth(NUM_SETS), .MaskW(1), .HasReset(1'b1)) u_dirty (
    .clk_i   (clk),
    .rst_i   (rst),
    .addr_i  (idx),
    .we_i    (store_hit | fill | wb_done),
    .wmask_i (1'b1),
    .wdata_i (store_hit),
    .rdata_o (dirty_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      miss_addr_q    <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req && !hit) begin
            miss_addr_q <= data_addr;
            if (valid_rd && dirty_rd) begin
              state_q        <= WRITEBACK;
              pmem_write_q   <= 1'b1;
              pmem_address_q <= {tag_rd, idx, 5'b0};
            end else begin
              state_q        <= ALLOCATE;
              pmem_read_q    <= 1'b1;
              pmem_address_q <= {data_addr[31:5], 5'b0};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            state_q        <= ALLOCATE;
            pmem_write_q   <= 1'b0;
            pmem_read_q    <= 1'b1;
            pmem_address_q <= {miss_addr_q[31:5], 5'b0};
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            state_q     <= IDLE;
            pmem_read_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_no_dual_req : assert property (@(posedge clk) disable iff (rst) !(data_read && data_write));

endmodule
